uart_tx_ctrl: RTL

//   UART transmit frame controller and serializer. Accepts one parallel word per frame
//   and drives TX_OUT one bit per CLK: start, data LSB-first, optional parity, stop.

---
 rtl/uart_tx_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: serializes one parallel word per frame as
// start, data LSB-first, optional parity (taken from parity_calc) and stop.
module uart_tx_ctrl #(
    parameter int Data_WD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [Data_WD-1:0] P_DATA,
    input  logic               Data_Valid,
    input  logic               PAR_EN,
    input  logic               par_bit,
    output logic               TX_OUT,
    output logic               Busy
);

    localparam int CNT_W = $clog2(Data_WD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Data_WD - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [Data_WD-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               par_en_q, par_en_d;
    logic               tx_out_q, tx_out_d;
    logic               busy_q, busy_d;

    // Next-state logic; outputs are computed for the state being entered so they leave flops.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        tx_out_d = tx_out_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d  = START;
                    shift_d  = P_DATA;
                    par_en_d = PAR_EN;
                    cnt_d    = '0;
                    tx_out_d = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    tx_out_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            START: begin
                // The first data bit is presented here, so the register is one shift ahead of the line.
                state_d  = DATA;
                tx_out_d = shift_q[0];
                shift_d  = shift_q >> 1'b1;
                cnt_d    = '0;
                busy_d   = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (par_en_q) begin
                        state_d  = PARITY;
                        tx_out_d = par_bit;
                    end else begin
                        state_d  = STOP;
                        tx_out_d = 1'b1;
                    end
                end else begin
                    tx_out_d = shift_q[0];
                    shift_d  = shift_q >> 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d  = STOP;
                tx_out_d = 1'b1;
                busy_d   = 1'b1;
            end
            STOP: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
        end
    end

    assign TX_OUT = tx_out_q;
    assign Busy   = busy_q;

endmodule
